// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time stimulus block.
package reaction_pkg;

  localparam int unsigned LedWidth = 10;

  // Right-shifting Fibonacci form: feedback bits 0,2,3,5 correspond to taps 16,14,13,11.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  localparam logic [LedWidth-1:0] LedAll = '1;

  typedef enum logic [2:0] {
    StIdle,
    StLights,
    StHold,
    StTiming,
    StDone,
    StFault
  } state_e;

endpackage

// File: rtl/reaction_stimulus_if.sv
// Player-facing and timing signals of the reaction stimulus block.
interface reaction_stimulus_if;
  import reaction_pkg::*;

  logic                tick_ms;
  logic                start;
  logic                KEY0;
  logic [LedWidth-1:0] ledr;
  logic                en_reaction_counter;
  logic                false_start;
  logic                timeout;
  logic                busy;

  modport master (
    output tick_ms, start, KEY0,
    input  ledr, en_reaction_counter, false_start, timeout, busy
  );

  modport slave (
    input  tick_ms, start, KEY0,
    output ledr, en_reaction_counter, false_start, timeout, busy
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // Advance one step per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LfsrSeed;
    end else begin
      q <= {^(q & LfsrTaps), q[15:1]};
    end
  end

endmodule

// File: rtl/reaction_stimulus.sv
// Start-light sequencer for a reaction timer: lights, random hold, timed window, fault handling.
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int unsigned LIGHT_MS     = 500,
  parameter int unsigned MIN_DELAY_MS = 250,
  parameter int unsigned MAX_REACT_MS = 9999
) (
  input logic               clk,
  input logic               rst_n,
  reaction_stimulus_if.slave bus
);

  localparam int unsigned MsW   = 14;
  localparam int unsigned HoldW = 13;
  localparam logic [MsW-1:0] LightLast = MsW'(LIGHT_MS - 1);
  localparam logic [MsW-1:0] ReactLast = MsW'(MAX_REACT_MS - 1);

  state_e              state_q, state_d;
  logic [LedWidth-1:0] ledr_q, ledr_d;
  logic                en_q, en_d;
  logic                fs_q, fs_d;
  logic                to_q, to_d;
  logic                busy_q, busy_d;
  logic [MsW-1:0]      ms_q, ms_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                key_q;
  logic                press;
  logic [15:0]         lfsr;
  logic                unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:12];

  // Only a fresh rising edge of the button counts as a press.
  assign press = bus.KEY0 & ~key_q;

  // Next-state and next-output decode; every output is computed here and registered below.
  always_comb begin
    state_d = state_q;
    ledr_d  = ledr_q;
    en_d    = en_q;
    fs_d    = fs_q;
    to_d    = to_q;
    ms_d    = ms_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle, StDone, StFault: begin
        // Presses here are ignored, so start wins over a coincident press.
        if (bus.start) begin
          state_d = StLights;
          ledr_d  = '0;
          en_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
          ms_d    = '0;
          hold_d  = '0;
        end
      end
      StLights, StHold: begin
        if (press) begin
          // False start outranks any tick in the same cycle, including hold expiry.
          state_d = StFault;
          ledr_d  = LedAll;
          en_d    = 1'b0;
          fs_d    = 1'b1;
          ms_d    = '0;
          hold_d  = '0;
        end else if (bus.tick_ms && state_q == StLights) begin
          if (ms_q == LightLast) begin
            ledr_d = {ledr_q[LedWidth-2:0], 1'b1};
            ms_d   = '0;
            if (&ledr_q[LedWidth-2:0]) begin
              state_d = StHold;
              hold_d  = HoldW'(MIN_DELAY_MS) + HoldW'(lfsr[11:0]);
            end
          end else begin
            ms_d = ms_q + MsW'(1);
          end
        end else if (bus.tick_ms) begin
          if (hold_q <= HoldW'(1)) begin
            state_d = StTiming;
            ledr_d  = '0;
            en_d    = 1'b1;
            ms_d    = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HoldW'(1);
          end
        end
      end
      StTiming: begin
        // A press beats a coincident timeout tick.
        if (press) begin
          state_d = StDone;
          en_d    = 1'b0;
        end else if (bus.tick_ms) begin
          if (ms_q == ReactLast) begin
            state_d = StDone;
            en_d    = 1'b0;
            to_d    = 1'b1;
          end else begin
            ms_d = ms_q + MsW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        ledr_d  = '0;
        en_d    = 1'b0;
        fs_d    = 1'b0;
        to_d    = 1'b0;
        ms_d    = '0;
        hold_d  = '0;
      end
    endcase

    busy_d = (state_d == StLights) || (state_d == StHold) || (state_d == StTiming);
  end

  // State, counters, outputs and the button edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ledr_q  <= '0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      ms_q    <= '0;
      hold_q  <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ledr_q  <= ledr_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      ms_q    <= ms_d;
      hold_q  <= hold_d;
      key_q   <= bus.KEY0;
    end
  end

  assign bus.ledr                = ledr_q;
  assign bus.en_reaction_counter = en_q;
  assign bus.false_start         = fs_q;
  assign bus.timeout             = to_q;
  assign bus.busy                = busy_q;

endmodule
